serial_sub: RTL

SERIAL_SUB -- requirements
Module: serial_sub

---
 rtl/serial_pkg.sv | 11 +
 rtl/fsub_bit.sv | 13 +
 rtl/serial_sub.sv | 130 +++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/fsub_bit.sv
// One-bit full subtractor cell: d = x - y - bin, with borrow out.
module fsub_bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: computes a-b LSB-first over WIDTH cycles using one fsub_bit cell.
// Defining SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.
module serial_sub
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    // One extra bit so the counter can reach WIDTH without wrapping.
    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [CW-1:0]    cnt;
    logic             brw;
    logic             bit_d;
    logic             bit_bout;
    logic             load;
    logic             step;
    logic             last;

    fsub_bit u_cell (
        .x   (a_sh[0]),
        .y   (b_sh[0]),
        .bin (brw),
        .d   (bit_d),
        .bout(bit_bout)
    );

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                step = 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    last       = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Result bits enter from the MSB side so the word is aligned after the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh       <= '0;
            b_sh       <= '0;
            res_sh     <= '0;
            cnt        <= '0;
            brw        <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            done <= last;
            if (load) begin
                a_sh   <= a;
                b_sh   <= b;
                res_sh <= '0;
                cnt    <= '0;
                brw    <= 1'b0;
            end else if (step) begin
                a_sh   <= a_sh >> 1;
                b_sh   <= b_sh >> 1;
                res_sh <= {bit_d, res_sh[WIDTH-1:1]};
                cnt    <= cnt + 1'b1;
                brw    <= bit_bout;
            end
            if (last) begin
                diff       <= {bit_d, res_sh[WIDTH-1:1]};
                borrow_out <= bit_bout;
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb;
    logic b_msb;

    // The final cell output is the result MSB, so overflow is decided on the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (load) begin
                a_msb <= a[WIDTH-1];
                b_msb <= b[WIDTH-1];
            end
            if (last) ovf <= (a_msb != b_msb) && (bit_d != a_msb);
        end
    end
`endif

endmodule
